// File: rtl/miner_pkg.sv
// Shared sizes and state encodings for the miner work dispatcher and its UART byte receiver.
package miner_pkg;

   localparam int JOB_BYTES    = 108;
   localparam int RESULT_BYTES = 36;
   localparam int JOB_BITS     = JOB_BYTES * 8;
   localparam int RESULT_BITS  = RESULT_BYTES * 8;

   typedef enum logic [2:0] {
      IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      WAIT_RESULT
   } disp_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/dispatch_byte_rx.sv
// UART 8N1 byte receiver with a 2-flop input synchronizer; free-running, one strobe per good frame.
module dispatch_byte_rx
   import miner_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       serial_i,
   output logic [7:0] byte_o,
   output logic       byte_strobe_o,
   output logic       frame_err_o
);

   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             prev_q;
   rx_state_e        rxState_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bitIdx_q;
   logic [7:0]       shift_q;
   logic             stopSample;

   // prev_q lets the idle state react to a genuine high-to-low transition only
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= serial_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rxState_q <= RX_IDLE;
         cnt_q     <= '0;
         bitIdx_q  <= '0;
         shift_q   <= '0;
      end else begin
         case (rxState_q)
            RX_IDLE: begin
               cnt_q    <= '0;
               bitIdx_q <= '0;
               if (prev_q && !sync2_q) begin
                  rxState_q <= RX_START;
               end
            end
            RX_START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q     <= '0;
                  rxState_q <= sync2_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q    <= '0;
                  shift_q  <= {sync2_q, shift_q[7:1]};
                  bitIdx_q <= bitIdx_q + 1'b1;
                  if (bitIdx_q == 3'd7) begin
                     rxState_q <= RX_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q     <= '0;
                  rxState_q <= RX_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: rxState_q <= RX_IDLE;
         endcase
      end
   end

   // Strobe is asserted during the stop-sample cycle so the consumer acts on that same edge
   assign stopSample    = (rxState_q == RX_STOP) && (cnt_q == BIT_LAST);
   assign byte_o        = shift_q;
   assign byte_strobe_o = stopSample && sync2_q;
   assign frame_err_o   = stopSample && !sync2_q;

endmodule

// File: rtl/work_dispatcher.sv
// Sends a 108-byte job to the miner over UART, then collects a 36-byte result or times out.
module work_dispatcher
   import miner_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 10,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [JOB_BITS-1:0]    job_data,
   input  logic                   job_valid,
   output logic                   job_ready,
   output logic                   serial_out,
   input  logic                   serial_in,
   output logic [RESULT_BITS-1:0] result_data,
   output logic                   result_valid,
   output logic                   busy,
   output logic                   timeout
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);

   disp_state_e            state_q;
   logic [JOB_BITS-1:0]    shift_q;
   logic [6:0]             txByte_q;
   logic [CNT_W-1:0]       bitCnt_q;
   logic [2:0]             bitIdx_q;
   logic [6:0]             byteCnt_q;
   logic                   serial_q;
   logic [RESULT_BITS-9:0] resBuf_q;
   logic [5:0]             rxCount_q;
   logic [TO_W-1:0]        toCnt_q;
   logic [TO_W-1:0]        toCnt_d;
   logic [RESULT_BITS-1:0] result_q;
   logic                   resultValid_q;
   logic                   timeout_q;

   logic [7:0]             rxByte;
   logic                   rxStrobe;
   logic                   rxFrameErr;
   logic                   validByte;
   logic                   bitEnd;

   dispatch_byte_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk           (clk),
      .n_rst         (n_rst),
      .serial_i      (serial_in),
      .byte_o        (rxByte),
      .byte_strobe_o (rxStrobe),
      .frame_err_o   (rxFrameErr)
   );

   // A frame that failed its stop check never counts, even if both flags were ever raised together
   assign validByte = rxStrobe && !rxFrameErr;
   assign bitEnd    = (bitCnt_q == BIT_LAST);

   always_comb begin
      toCnt_d = toCnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= IDLE;
         shift_q       <= '0;
         txByte_q      <= '0;
         bitCnt_q      <= '0;
         bitIdx_q      <= '0;
         byteCnt_q     <= '0;
         serial_q      <= 1'b1;
         resBuf_q      <= '0;
         rxCount_q     <= '0;
         toCnt_q       <= '0;
         result_q      <= '0;
         resultValid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         resultValid_q <= 1'b0;
         timeout_q     <= 1'b0;

         if (state_q inside {TX_START, TX_DATA, TX_STOP}) begin
            bitCnt_q <= bitEnd ? '0 : bitCnt_q + 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (job_valid) begin
                  shift_q   <= job_data;
                  serial_q  <= 1'b0;
                  bitCnt_q  <= '0;
                  byteCnt_q <= '0;
                  state_q   <= TX_START;
               end
            end
            TX_START: begin
               // Bit 0 goes straight to the line; the other seven wait in txByte_q
               if (bitEnd) begin
                  serial_q <= shift_q[JOB_BITS-8];
                  txByte_q <= shift_q[JOB_BITS-1:JOB_BITS-7];
                  shift_q  <= {shift_q[JOB_BITS-9:0], 8'h00};
                  bitIdx_q <= '0;
                  state_q  <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (bitEnd) begin
                  if (bitIdx_q == 3'd7) begin
                     serial_q <= 1'b1;
                     state_q  <= TX_STOP;
                  end else begin
                     serial_q <= txByte_q[0];
                     txByte_q <= {1'b0, txByte_q[6:1]};
                     bitIdx_q <= bitIdx_q + 1'b1;
                  end
               end
            end
            TX_STOP: begin
               if (bitEnd) begin
                  if (byteCnt_q == 7'(JOB_BYTES - 1)) begin
                     toCnt_q   <= '0;
                     rxCount_q <= '0;
                     state_q   <= WAIT_RESULT;
                  end else begin
                     byteCnt_q <= byteCnt_q + 1'b1;
                     serial_q  <= 1'b0;
                     state_q   <= TX_START;
                  end
               end
            end
            WAIT_RESULT: begin
               // A completing byte takes priority over a timeout landing on the same edge
               if (validByte) begin
                  toCnt_q <= '0;
                  if (rxCount_q == 6'(RESULT_BYTES - 1)) begin
                     result_q      <= {resBuf_q, rxByte};
                     resultValid_q <= 1'b1;
                     rxCount_q     <= '0;
                     state_q       <= IDLE;
                  end else begin
                     resBuf_q  <= {resBuf_q[RESULT_BITS-17:0], rxByte};
                     rxCount_q <= rxCount_q + 1'b1;
                  end
               end else if (toCnt_d == TO_W'(TIMEOUT_CYCLES)) begin
                  timeout_q <= 1'b1;
                  toCnt_q   <= '0;
                  rxCount_q <= '0;
                  state_q   <= IDLE;
               end else begin
                  toCnt_q <= toCnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign job_ready    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign serial_out   = serial_q;
   assign result_data  = result_q;
   assign result_valid = resultValid_q;
   assign timeout      = timeout_q;

endmodule

// File: doc/work_dispatcher.md
WORK_DISPATCHER -- requirements
Module: work_dispatcher

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, clock cycles per UART bit period (legal: 4 or more).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, idle cycles allowed between result bytes before abort.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 job_data  input  864  work packet to send to the miner.
REQ-006 job_valid  input  1  job_data is valid.
REQ-007 job_ready  output  1  dispatcher can accept a job.
REQ-008 serial_out  output  1  UART 8N1 line to the miner serial_in, idle high.
REQ-009 serial_in  input  1  UART 8N1 line from the miner serial_out, asynchronous.
REQ-010 result_data  output  288  last complete result received.
REQ-011 result_valid  output  1  one-cycle pulse; result_data is updated.
REQ-012 busy  output  1  high from job acceptance until result or timeout.
REQ-013 timeout  output  1  one-cycle pulse; result wait aborted.

Function
REQ-014 Handshake: a job is accepted on the rising edge where job_valid and job_ready are both high; job_ready = (state == IDLE).
REQ-015 On acceptance, job_data is captured in a 864-bit shift register; a later change on job_data has no effect.
REQ-016 TX framing: 108 bytes; byte 0 = job_data[863:856] first, byte 107 = job_data[7:0] last; bits within a byte go LSB first.
REQ-017 Each byte is sent as start bit (0), 8 data bits, and stop bit (1), each bit held CLKS_PER_BIT cycles, with no idle gap between bytes.
REQ-018 serial_out drops to 0 in the cycle after acceptance; total TX time = 1080*CLKS_PER_BIT cycles.
REQ-019 States: IDLE -> TX_START -> TX_DATA -> TX_STOP -> (TX_START if bytes remain, else WAIT_RESULT) -> IDLE.
REQ-020 RX path: 2-flop synchronizer; a falling edge starts a frame, sampled at CLKS_PER_BIT/2 (start re-check) and then every CLKS_PER_BIT.
REQ-021 A start bit read as 1 at mid-bit is a glitch: return to RX idle, no byte.
REQ-022 A stop bit read as 0 is a framing error: discard the byte, do not count it.
REQ-023 The receiver runs continuously; bytes completing outside WAIT_RESULT are discarded.
REQ-024 In WAIT_RESULT, the first valid byte goes to result bits [287:280]; after 36 bytes, result_data updates and result_valid pulses in the cycle after the 36th stop-bit sample.
REQ-025 On that same edge the state returns to IDLE, and job_ready is high in the next cycle.
REQ-026 Timeout counter clears on entry to WAIT_RESULT and on each valid byte, and increments each other cycle.
REQ-027 When the count reaches TIMEOUT_CYCLES: timeout pulses, partial bytes are dropped, result_data is unchanged, and the state returns to IDLE.
REQ-028 If the 36th byte and the timeout occur in the same cycle, the byte wins: result_valid pulses, timeout does not.
REQ-029 result_data holds its value until the next complete result.

Reset
REQ-030 While n_rst is low: state IDLE, serial_out=1, job_ready=1 after release, busy=0, result_valid=0, timeout=0, result_data=0, all counters 0, synchronizer flops=1.
REQ-031 Reset asserted mid-frame aborts immediately; serial_out returns high asynchronously and the partial frame is not resumed.

Structure
REQ-032 Package miner_pkg holds JOB_BYTES=108, RESULT_BYTES=36, the state enum type, and the RX state enum type.
REQ-033 One sub-module, dispatch_byte_rx (synchronizer plus byte receiver), outputs byte[7:0], byte_strobe, and frame_err.
REQ-034 The TX FSM, shift register, and result assembly stay in work_dispatcher.

Verification
REQ-035 Job 864'h0102...6C (byte i = i+1) -> serial_out shows 108 frames with values 0x01..0x6C in order, each 10 bit times, busy=1 throughout.
REQ-036 After TX, inject 36 bytes 0xA0..0xC3 -> result_data=288'hA0A1...C3, a single result_valid pulse, job_ready=1 on the next cycle.
REQ-037 TIMEOUT_CYCLES=500, inject 10 bytes then silence -> timeout pulses 500 cycles after the 10th byte, result_data unchanged, state IDLE.
REQ-038 Result byte 5 sent with stop bit 0 -> byte dropped; 37 bytes sent in total yield a valid result made of bytes 0-4 and 6-36.
REQ-039 n_rst pulsed low during TX byte 40 -> serial_out=1 at once; a new job then restarts from byte 0.
REQ-040 Hold job_valid high during TX and drive a 2-cycle low glitch on serial_in -> no second acceptance and no byte received.
